// File: rtl/equiv_checker.sv
// Self-checking equivalence harness: drives LFSR stimulus and reset into golden and
// implementation DUT copies, compares their outputs and reports pass/fail.
// Optional first-failure capture ports are enabled by defining EQUIV_FIRST_FAIL_EN.
module equiv_checker #(
    parameter int          IN_W        = 32,
    parameter int          OUT_W       = 32,
    parameter int          NUM_VECTORS = 1000,
    parameter int          SAMPLE_GAP  = 2,
    parameter int          RST_CYCLES  = 2,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  stim_out,
    output logic             dut_rst,
    input  logic [OUT_W-1:0] gold_in,
    input  logic [OUT_W-1:0] impl_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
`ifdef EQUIV_FIRST_FAIL_EN
    ,
    output logic             fail_valid,
    output logic [CNT_W-1:0] fail_idx,
    output logic [OUT_W-1:0] fail_gold,
    output logic [OUT_W-1:0] fail_impl
`endif
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] MASK     = 32'h80200003;
    localparam int          PH_MAX   = (RST_CYCLES > SAMPLE_GAP) ? RST_CYCLES : SAMPLE_GAP;
    localparam int          PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    generate
        if (IN_W < 1 || IN_W > 32) begin : g_bad_in_w
            $error("equiv_checker: IN_W must be 1..32");
        end
        if (NUM_VECTORS < 1 || SAMPLE_GAP < 1 || RST_CYCLES < 1) begin : g_bad_len
            $error("equiv_checker: NUM_VECTORS, SAMPLE_GAP and RST_CYCLES must be >= 1");
        end
        if (64'(NUM_VECTORS) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
            $error("equiv_checker: NUM_VECTORS does not fit in CNT_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DUT_RST, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PH_W-1:0] ph;
    logic [31:0]     lfsr, lfsr_step;
    logic            go, ph_last, cmp_en, miss, last_vec;

    always_comb begin
        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
        go        = start && (state == IDLE || state == DONE);
        ph_last   = (state == DUT_RST) ? (ph == PH_W'(RST_CYCLES - 1))
                                       : (ph == PH_W'(SAMPLE_GAP - 1));
        // One compare per phase: the reset check and the last cycle of each vector
        cmp_en    = (state == DUT_RST || state == RUN) && ph_last;
        miss      = cmp_en && (gold_in != impl_in);
        last_vec  = (vec_cnt == CNT_W'(NUM_VECTORS - 1));
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DUT_RST;
            DUT_RST:    if (ph_last) state_nxt = RUN;
            RUN:        if (ph_last && last_vec) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr         <= SEED_EFF;
            ph           <= '0;
            stim_out     <= '0;
            dut_rst      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
`ifdef EQUIV_FIRST_FAIL_EN
            fail_valid   <= 1'b0;
            fail_idx     <= '0;
            fail_gold    <= '0;
            fail_impl    <= '0;
`endif
        end else if (go) begin
            lfsr         <= SEED_EFF;
            ph           <= '0;
            stim_out     <= '0;
            dut_rst      <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            vec_cnt      <= '0;
            mismatch_cnt <= '0;
`ifdef EQUIV_FIRST_FAIL_EN
            fail_valid   <= 1'b0;
            fail_idx     <= '0;
            fail_gold    <= '0;
            fail_impl    <= '0;
`endif
        end else begin
            if (state == DUT_RST || state == RUN)
                ph <= ph_last ? '0 : ph + 1'b1;
            if (miss && mismatch_cnt != '1)
                mismatch_cnt <= mismatch_cnt + 1'b1;
            if (cmp_en && state == RUN)
                vec_cnt <= vec_cnt + 1'b1;
            // Next vector is registered at the edge that closes the previous phase
            if (ph_last && (state == DUT_RST || (state == RUN && !last_vec))) begin
                lfsr     <= lfsr_step;
                stim_out <= lfsr_step[IN_W-1:0];
            end
            if (state == DUT_RST && ph_last)
                dut_rst <= 1'b0;
            if (state == RUN && ph_last && last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (mismatch_cnt == '0) && !miss;
            end
`ifdef EQUIV_FIRST_FAIL_EN
            if (miss && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_idx   <= vec_cnt;
                fail_gold  <= gold_in;
                fail_impl  <= impl_in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_equiv_checker.sv
// Scoreboard bench for equiv_checker: stimulus pushes expected run results and
// stimulus vectors; monitors pop and compare as the DUTs present them.
module tb_equiv_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start1, flip0;
    logic [31:0] stim0;
    logic        dut_rst0, busy0, done0, pass0;
    logic [15:0] vec0, mm0;
    logic [31:0] gold0, impl0;
    logic [7:0]  stim1;
    logic        dut_rst1, busy1, done1, pass1;
    logic [1:0]  vec1, mm1;
    logic [7:0]  gold1, impl1;

    localparam logic [31:0] V2 = 32'hC0300002;
    localparam logic [31:0] V3 = 32'h60180001;

    // Stand-in DUT copies: golden is a fixed xor of the stimulus
    assign gold0 = stim0 ^ 32'h5A5A5A5A;
    assign impl0 = gold0 ^ {31'd0, flip0 && (stim0 == V3)};
    assign gold1 = stim1 ^ 8'hA5;
    assign impl1 = ~gold1;

`ifdef EQUIV_FIRST_FAIL_EN
    logic        fv0, fv1;
    logic [15:0] fidx0;
    logic [1:0]  fidx1;
    logic [31:0] fg0, fi0;
    logic [7:0]  fg1, fi1;
`endif

    equiv_checker #(.IN_W(32), .OUT_W(32), .NUM_VECTORS(4), .SAMPLE_GAP(2),
                    .RST_CYCLES(2), .CNT_W(16), .SEED(32'h1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .stim_out(stim0), .dut_rst(dut_rst0),
        .gold_in(gold0), .impl_in(impl0), .busy(busy0), .done(done0), .pass(pass0),
        .vec_cnt(vec0), .mismatch_cnt(mm0)
`ifdef EQUIV_FIRST_FAIL_EN
        , .fail_valid(fv0), .fail_idx(fidx0), .fail_gold(fg0), .fail_impl(fi0)
`endif
    );

    equiv_checker #(.IN_W(8), .OUT_W(8), .NUM_VECTORS(3), .SAMPLE_GAP(2),
                    .RST_CYCLES(2), .CNT_W(2), .SEED(32'h0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stim_out(stim1), .dut_rst(dut_rst1),
        .gold_in(gold1), .impl_in(impl1), .busy(busy1), .done(done1), .pass(pass1),
        .vec_cnt(vec1), .mismatch_cnt(mm1)
`ifdef EQUIV_FIRST_FAIL_EN
        , .fail_valid(fv1), .fail_idx(fidx1), .fail_gold(fg1), .fail_impl(fi1)
`endif
    );

    typedef struct {
        logic [31:0] vec, mm, bc, rc, fidx, fxor;
        logic        pass, fval;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [31:0] sq[$];
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int vec, input int mm, input bit ps, input int bc,
                                input bit fval, input int fidx, input int fxor);
        exp_t e;
        e.vec = vec; e.mm = mm; e.pass = ps; e.bc = bc; e.rc = 2;
        e.fval = fval; e.fidx = fidx; e.fxor = fxor;
        return e;
    endfunction

    function automatic logic [31:0] lfsr_ref(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    task automatic push_model_stims();
        logic [31:0] x = 32'h1;
        repeat (4) begin
            x = lfsr_ref(x);
            sq.push_back(x);
        end
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 60; i++) begin
            if ((which == 0) ? done0 : done1) return;
            @(negedge clk);
        end
        chk("done_timeout", (which == 0) ? done0 : done1, 1);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_stim"}, stim0, 0);
        chk({tag, "_dut_rst"}, dut_rst0, 0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_pass"}, pass0, 0);
        chk({tag, "_vec"}, vec0, 0);
        chk({tag, "_mm"}, mm0, 0);
    endtask

    // Monitor for u0: stimulus vectors and end-of-run results
    initial begin
        logic [31:0] prev_stim = '0;
        logic        prev_rst = 1'b0, prev_done = 1'b0;
        int          bc = 0, rc = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc = 0; rc = 0;
            end else begin
                if (busy0) bc++;
                if (dut_rst0) rc++;
                if (busy0 && !dut_rst0 && (prev_rst || stim0 != prev_stim))
                    chk("stim0", stim0, (sq.size() > 0) ? sq.pop_front() : 'x);
                if (done0 && !prev_done) begin
                    e = (q0.size() > 0) ? q0.pop_front() : mk(-1, -1, 1'b0, -1, 1'b0, -1, -1);
                    chk("run0_vec_cnt", vec0, e.vec);
                    chk("run0_mismatch_cnt", mm0, e.mm);
                    chk("run0_pass", pass0, e.pass);
                    chk("run0_busy_cycles", bc, e.bc);
                    chk("run0_dut_rst_cycles", rc, e.rc);
`ifdef EQUIV_FIRST_FAIL_EN
                    chk("run0_fail_valid", fv0, e.fval);
                    if (e.fval) begin
                        chk("run0_fail_idx", fidx0, e.fidx);
                        chk("run0_fail_xor", fg0 ^ fi0, e.fxor);
                    end
`endif
                    bc = 0; rc = 0;
                end
            end
            prev_stim = stim0;
            prev_rst  = dut_rst0;
            prev_done = done0;
        end
    end

    // Monitor for u1: saturating mismatch counter configuration
    initial begin
        logic prev_done = 1'b0;
        int   bc = 0, rc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc = 0; rc = 0;
            end else begin
                if (busy1) bc++;
                if (dut_rst1) rc++;
                if (done1 && !prev_done) begin
                    e = (q1.size() > 0) ? q1.pop_front() : mk(-1, -1, 1'b0, -1, 1'b0, -1, -1);
                    chk("run1_vec_cnt", vec1, e.vec);
                    chk("run1_mismatch_cnt", mm1, e.mm);
                    chk("run1_pass", pass1, e.pass);
                    chk("run1_busy_cycles", bc, e.bc);
                    chk("run1_dut_rst_cycles", rc, e.rc);
`ifdef EQUIV_FIRST_FAIL_EN
                    chk("run1_fail_valid", fv1, e.fval);
                    if (e.fval) begin
                        chk("run1_fail_idx", fidx1, e.fidx);
                        chk("run1_fail_xor", fg1 ^ fi1, e.fxor);
                    end
`endif
                    bc = 0; rc = 0;
                end
            end
            prev_done = done1;
        end
    end

    initial begin
        logic [31:0] hc[4];
        hc[0] = 32'h80200003; hc[1] = 32'hC0300002; hc[2] = 32'h60180001; hc[3] = 32'hB02C0003;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; flip0 = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset0("reset");
        chk("reset_u1_busy", busy1, 0);
        chk("reset_u1_mm", mm1, 0);
        rst = 1'b0;

        // Run A: identical copies, hand-computed LFSR sequence
        q0.push_back(mk(4, 0, 1'b1, 10, 1'b0, 0, 0));
        for (int i = 0; i < 4; i++) sq.push_back(hc[i]);
        pulse_start(0);
        wait_done(0);

        // Run B: single-bit difference during vector 3, restarted from DONE
        flip0 = 1'b1;
        q0.push_back(mk(4, 1, 1'b0, 10, 1'b1, 2, 1));
        push_model_stims();
        pulse_start(0);
        wait_done(0);
        flip0 = 1'b0;

        // Abort mid-run at vector 2
        push_model_stims();
        pulse_start(0);
        for (int i = 0; i < 40 && !(stim0 == V2 && !dut_rst0); i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset0("abort");
        @(negedge clk);
        rst = 1'b0;
        sq.delete();

        // Run C: a start pulse inside RUN must be ignored
        q0.push_back(mk(4, 0, 1'b1, 10, 1'b0, 0, 0));
        push_model_stims();
        pulse_start(0);
        repeat (5) @(negedge clk);
        pulse_start(0);
        wait_done(0);

        // Runs D and E: back-to-back restarts from DONE
        repeat (2) begin
            q0.push_back(mk(4, 0, 1'b1, 10, 1'b0, 0, 0));
            push_model_stims();
            pulse_start(0);
            chk("restart_vec_cleared", vec0, 0);
            wait_done(0);
        end

        // u1: every compare fails; counter must saturate at 3
        q1.push_back(mk(3, 3, 1'b0, 8, 1'b1, 0, 32'hFF));
        pulse_start(1);
        wait_done(1);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("stim_q_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
